// File: rtl/piso_serializer.sv
// -----------------------------------------------------------------------------
// piso_serializer
//   Parallel-in serial-out stage. Takes a WIDTH-bit word over a valid/ready
//   handshake and shifts it out one bit per clock on ser_out. ser_en marks the
//   data-bit cycles so a downstream deserializer can rebuild the word in order.
//   Back-to-back frames run with no gap: a new word can be accepted during the
//   final cycle of the current frame.
//
// Optional feature (compile-time macro):
//   PARITY_BIT_EN : append one even-parity cycle after the data bits
//                   (ser_en=0, par_vld=1). Undefined: data bits only and
//                   par_vld is tied low.
//
// Parameters:
//   WIDTH     : data word width, >= 2
//   MSB_FIRST : 0 = bit 0 first, 1 = bit WIDTH-1 first
//
// Ports:
//   clk        : clock, all state on posedge
//   rst        : synchronous reset, active-high
//   din        : parallel word, captured on an accepting edge
//   din_valid  : upstream word available
//   din_ready  : block can accept this cycle
//   ser_out    : registered serial bit
//   ser_en     : registered, high on data-bit cycles
//   par_vld    : registered, high on the parity cycle
//   word_done  : registered, one-cycle pulse on the last cycle of a frame
//   busy       : registered, high while a frame is on the wire
// -----------------------------------------------------------------------------
module piso_serializer #(
    parameter int WIDTH     = 10,
    parameter bit MSB_FIRST = 1'b0
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] din,
    input  logic             din_valid,
    output logic             din_ready,
    output logic             ser_out,
    output logic             ser_en,
    output logic             par_vld,
    output logic             word_done,
    output logic             busy
);

    localparam int             CW   = $clog2(WIDTH);
    localparam logic [CW-1:0]  LAST = CW'(WIDTH - 1);

`ifdef PARITY_BIT_EN
    typedef enum logic [1:0] {S_IDLE = 2'd0, S_SHIFT = 2'd1, S_PARITY = 2'd2} state_e;
`else
    typedef enum logic [1:0] {S_IDLE = 2'd0, S_SHIFT = 2'd1} state_e;
`endif

    state_e           state_q, state_d;
    logic [CW-1:0]    cnt_q, cnt_d;       // index of the bit currently on ser_out
    logic [WIDTH-1:0] word_q, word_d;     // frame word, frozen at acceptance
    logic             ser_out_q, ser_out_d;
    logic             ser_en_q, ser_en_d;
    logic             par_vld_q, par_vld_d;
    logic             done_q, done_d;
    logic             busy_q, busy_d;
    logic             accept;

    // Map transmit order k to the word bit index.
    function automatic logic pick(input logic [WIDTH-1:0] w, input logic [CW-1:0] k);
        if (MSB_FIRST) return w[LAST - k];
        else           return w[k];
    endfunction

    // ---------------- state register ----------------
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= S_IDLE;
            cnt_q     <= '0;
            word_q    <= '0;
            ser_out_q <= 1'b0;
            ser_en_q  <= 1'b0;
            par_vld_q <= 1'b0;
            done_q    <= 1'b0;
            busy_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            word_q    <= word_d;
            ser_out_q <= ser_out_d;
            ser_en_q  <= ser_en_d;
            par_vld_q <= par_vld_d;
            done_q    <= done_d;
            busy_q    <= busy_d;
        end
    end

    // ---------------- next-state logic ----------------
    // Output flops are loaded one edge ahead, so the value computed here is
    // what appears on the pins during the following cycle.
    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        word_d    = word_q;
        ser_out_d = 1'b0;
        ser_en_d  = 1'b0;
        par_vld_d = 1'b0;
        done_d    = 1'b0;
        busy_d    = 1'b0;

        case (state_q)
            S_IDLE: begin
                if (accept) begin
                    state_d   = S_SHIFT;
                    word_d    = din;
                    cnt_d     = '0;
                    ser_out_d = pick(din, '0);
                    ser_en_d  = 1'b1;
                    busy_d    = 1'b1;
                end
            end

            S_SHIFT: begin
                if (cnt_q != LAST) begin
                    cnt_d     = cnt_q + 1'b1;
                    ser_out_d = pick(word_q, cnt_q + 1'b1);
                    ser_en_d  = 1'b1;
                    busy_d    = 1'b1;
`ifndef PARITY_BIT_EN
                    done_d    = (cnt_q + 1'b1 == LAST);
`endif
                end else begin
`ifdef PARITY_BIT_EN
                    state_d   = S_PARITY;
                    ser_out_d = ^word_q;
                    par_vld_d = 1'b1;
                    done_d    = 1'b1;
                    busy_d    = 1'b1;
`else
                    // Last data bit on the wire: chain straight into the next word.
                    if (accept) begin
                        word_d    = din;
                        cnt_d     = '0;
                        ser_out_d = pick(din, '0);
                        ser_en_d  = 1'b1;
                        busy_d    = 1'b1;
                    end else begin
                        state_d = S_IDLE;
                    end
`endif
                end
            end

`ifdef PARITY_BIT_EN
            S_PARITY: begin
                if (accept) begin
                    state_d   = S_SHIFT;
                    word_d    = din;
                    cnt_d     = '0;
                    ser_out_d = pick(din, '0);
                    ser_en_d  = 1'b1;
                    busy_d    = 1'b1;
                end else begin
                    state_d = S_IDLE;
                end
            end
`endif

            default: state_d = S_IDLE;
        endcase
    end

    // ---------------- output logic ----------------
    always_comb begin
        din_ready = 1'b0;
        if (!rst) begin
            case (state_q)
                S_IDLE:   din_ready = 1'b1;
`ifdef PARITY_BIT_EN
                S_PARITY: din_ready = 1'b1;
                S_SHIFT:  din_ready = 1'b0;
`else
                S_SHIFT:  din_ready = (cnt_q == LAST);
`endif
                default:  din_ready = 1'b0;
            endcase
        end
    end

    assign accept    = din_valid & din_ready;
    assign ser_out   = ser_out_q;
    assign ser_en    = ser_en_q;
    assign par_vld   = par_vld_q;
    assign word_done = done_q;
    assign busy      = busy_q;

endmodule
